// File: rtl/sum_diff_checker_pkg.sv
// Shared types and constants for the sum/difference read-back checker.
package sum_diff_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sum_diff_state_t;

    localparam int SD_DATA_W = 8;
    localparam int SD_ADDR_W = 9;
    localparam int SD_DEPTH  = 512;

    localparam logic [1:0] ERR_SUM  = 2'b01;
    localparam logic [1:0] ERR_DIFF = 2'b10;

    // Packs the two per-field error flags into the reported kind code.
    function automatic logic [1:0] err_kind(input logic sum_err, input logic diff_err);
        return (sum_err ? ERR_SUM : 2'b00) | (diff_err ? ERR_DIFF : 2'b00);
    endfunction

endpackage

// File: rtl/sum_diff_checker_if.sv
// Shared read bus for the four RAM read ports (A, B, SUM, DIFF).
interface sum_diff_checker_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) ();
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] diff_q;

    // The checker drives the address and consumes the read data.
    modport master (
        output rd_addr,
        input  op_a_q,
        input  op_b_q,
        input  sum_q,
        input  diff_q
    );

    // The RAM side answers the shared address with its read data.
    modport slave (
        input  rd_addr,
        output op_a_q,
        output op_b_q,
        output sum_q,
        output diff_q
    );
endinterface

// File: rtl/sum_diff_checker_compare.sv
// Combinational recompute of A+B and A-B (modular) against stored results.
module sum_diff_compare
    import sum_diff_pkg::*;
#(
    parameter int DATA_W = SD_DATA_W
) (
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    input  logic [DATA_W-1:0] i_sum,
    input  logic [DATA_W-1:0] i_diff,
    output logic [1:0]        o_err
);
    logic [DATA_W-1:0] w_sum_ref;
    logic [DATA_W-1:0] w_diff_ref;

    // Carry and borrow fall off the top: results are compared mod 2^DATA_W.
    always_comb begin
        w_sum_ref  = i_op_a + i_op_b;
        w_diff_ref = i_op_a - i_op_b;
        o_err      = err_kind(i_sum != w_sum_ref, i_diff != w_diff_ref);
    end
endmodule

// File: rtl/sum_diff_checker.sv
// Read-back verifier: sweeps all addresses, recomputes sum/diff, counts
// failing addresses and records the first failing address and its kind.
module sum_diff_checker
    import sum_diff_pkg::*;
#(
    parameter int DATA_W = SD_DATA_W,
    parameter int ADDR_W = SD_ADDR_W
) (
    input  logic                  CLOCK_50_I,
    input  logic                  resetn,
    input  logic                  start,
    sum_diff_checker_if.master    ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W:0]       mismatch_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [1:0]            first_err_kind,
    output logic                  first_err_valid
);
    sum_diff_state_t   r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_done;

    logic              r_cmp_vld_p1;
    logic [ADDR_W-1:0] r_cmp_addr_p1;

    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W-1:0] r_first_addr;
    logic [1:0]        r_first_kind;
    logic              r_first_vld;

    logic [1:0]        w_err;
    logic              w_enter_read;
    logic              w_last_addr;

    assign w_enter_read = (r_state == S_IDLE) && start;
    assign w_last_addr  = (r_rd_addr == {ADDR_W{1'b1}});

    sum_diff_compare #(.DATA_W(DATA_W)) u_compare (
        .i_op_a (ram.op_a_q),
        .i_op_b (ram.op_b_q),
        .i_sum  (ram.sum_q),
        .i_diff (ram.diff_q),
        .o_err  (w_err)
    );

    // Sweep FSM: walks the read address and produces registered busy/done.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rd_addr <= '0;
                    if (start) begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    // Address wraps to 0 on the last step, leaving 0 in DRAIN.
                    r_rd_addr <= r_rd_addr + 1'b1;
                    if (w_last_addr) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency stage p1: address whose RAM data is on the bus this cycle.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_cmp_vld_p1  <= 1'b0;
            r_cmp_addr_p1 <= '0;
        end else begin
            r_cmp_vld_p1  <= (r_state == S_READ);
            r_cmp_addr_p1 <= r_rd_addr;
        end
    end

    // Result accumulation: per-address mismatch count and first failure capture.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_first_addr <= '0;
            r_first_kind <= 2'b00;
            r_first_vld  <= 1'b0;
        end else if (w_enter_read) begin
            r_cnt        <= '0;
            r_first_addr <= '0;
            r_first_kind <= 2'b00;
            r_first_vld  <= 1'b0;
        end else if (r_cmp_vld_p1 && (w_err != 2'b00)) begin
            // At most 2^ADDR_W failures, so the ADDR_W+1 bit count never wraps.
            r_cnt <= r_cnt + (ADDR_W+1)'(1);
            if (!r_first_vld) begin
                r_first_addr <= r_cmp_addr_p1;
                r_first_kind <= w_err;
                r_first_vld  <= 1'b1;
            end
        end
    end

    assign ram.rd_addr     = r_rd_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_done && (r_cnt == '0);
    assign mismatch_count  = r_cnt;
    assign first_err_addr  = r_first_addr;
    assign first_err_kind  = r_first_kind;
    assign first_err_valid = r_first_vld;

endmodule

// File: tb/tb_sum_diff_checker.sv
// Bench for sum_diff_checker: behavioural RAMs plus a reference model that
// scans the memory images with plain integer arithmetic.
module tb_sum_diff_checker;
    import sum_diff_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk;
    logic resetn;
    logic start;
    logic busy, done, pass, first_err_valid;
    logic [AW:0]   mismatch_count;
    logic [AW-1:0] first_err_addr;
    logic [1:0]    first_err_kind;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    logic [DW-1:0] mem_s [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    int n_vec;
    int n_err;

    sum_diff_checker_if #(.DATA_W(DW), .ADDR_W(AW)) ram ();

    sum_diff_checker #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLOCK_50_I      (clk),
        .resetn          (resetn),
        .start           (start),
        .ram             (ram.master),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .mismatch_count  (mismatch_count),
        .first_err_addr  (first_err_addr),
        .first_err_kind  (first_err_kind),
        .first_err_valid (first_err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four synchronous RAMs with one cycle of read latency.
    always @(posedge clk) begin
        ram.op_a_q <= mem_a[ram.rd_addr];
        ram.op_b_q <= mem_b[ram.rd_addr];
        ram.sum_q  <= mem_s[ram.rd_addr];
        ram.diff_q <= mem_d[ram.rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_results();
        for (int k = 0; k < DEPTH; k++) begin
            mem_s[k] = 8'((int'(mem_a[k]) + int'(mem_b[k])) % 256);
            mem_d[k] = 8'((int'(mem_a[k]) - int'(mem_b[k]) + 256) % 256);
        end
    endtask

    task automatic fill_consistent();
        for (int k = 0; k < DEPTH; k++) begin
            mem_a[k] = 8'(k % 256);
            mem_b[k] = 8'((3 * k) % 256);
        end
        fill_results();
    endtask

    // Reference: scan the images address by address, integer arithmetic.
    task automatic model(output int cnt, output int faddr, output int fkind);
        int  s_exp, d_exp, kind;
        bit  found;
        cnt = 0; faddr = 0; fkind = 0; found = 0;
        for (int k = 0; k < DEPTH; k++) begin
            s_exp = (int'(mem_a[k]) + int'(mem_b[k])) % 256;
            d_exp = (int'(mem_a[k]) - int'(mem_b[k]) + 256) % 256;
            kind  = ((int'(mem_s[k]) != s_exp) ? 1 : 0) + ((int'(mem_d[k]) != d_exp) ? 2 : 0);
            if (kind != 0) begin
                cnt++;
                if (!found) begin
                    found = 1;
                    faddr = k;
                    fkind = kind;
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".rd_addr"}, 32'(ram.rd_addr), 32'd0);
        check({tag, ".busy"},    32'(busy), 32'd0);
        check({tag, ".done"},    32'(done), 32'd0);
        check({tag, ".pass"},    32'(pass), 32'd0);
        check({tag, ".count"},   32'(mismatch_count), 32'd0);
        check({tag, ".faddr"},   32'(first_err_addr), 32'd0);
        check({tag, ".fkind"},   32'(first_err_kind), 32'd0);
        check({tag, ".fvalid"},  32'(first_err_valid), 32'd0);
        check({tag, ".state"},   32'(dut.r_state), 32'(S_IDLE));
    endtask

    // Full sweep: latency to done, results against the model, hold, release.
    task automatic run_sweep(input string tag);
        int edges, cnt, faddr, fkind;
        edges = 0;
        model(cnt, faddr, fkind);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        check({tag, ".addr0"},   32'(ram.rd_addr), 32'd0);
        while (!done && edges < 600) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, ".latency"},    32'(edges), 32'd513);
        check({tag, ".busy_off"},   32'(busy), 32'd0);
        check({tag, ".addr_done"},  32'(ram.rd_addr), 32'd0);
        check({tag, ".count"},      32'(mismatch_count), 32'(cnt));
        check({tag, ".fvalid"},     32'(first_err_valid), 32'(cnt != 0));
        check({tag, ".faddr"},      32'(first_err_addr), 32'(faddr));
        check({tag, ".fkind"},      32'(first_err_kind), 32'(fkind));
        check({tag, ".pass"},       32'(pass), 32'(cnt == 0));
        repeat (4) @(posedge clk);
        #1;
        check({tag, ".hold_done"},  32'(done), 32'd1);
        check({tag, ".hold_count"}, 32'(mismatch_count), 32'(cnt));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".rel_done"},   32'(done), 32'd0);
        check({tag, ".rel_state"},  32'(dut.r_state), 32'(S_IDLE));
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        start  = 1'b0;
        resetn = 1'b0;
        fill_consistent();

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Consistent images.
        run_sweep("clean");

        // Single SUM corruption.
        mem_s[37] = mem_s[37] + 8'd1;
        run_sweep("sum37");
        fill_consistent();

        // DIFF corrupted at both ends; the top address is compared in DRAIN.
        mem_d[0]   = mem_d[0] + 8'd1;
        mem_d[511] = mem_d[511] + 8'd1;
        run_sweep("diff_ends");
        check("diff_ends.count2", 32'(mismatch_count), 32'd2);

        // Carry and borrow wrap.
        for (int k = 0; k < DEPTH; k++) begin
            mem_a[k] = 8'hFF;
            mem_b[k] = 8'h01;
            mem_s[k] = 8'h00;
            mem_d[k] = 8'hFE;
        end
        run_sweep("wrap");

        // Every result wrong in both fields.
        for (int k = 0; k < DEPTH; k++) begin
            mem_a[k] = 8'h20;
            mem_b[k] = 8'h03;
            mem_s[k] = 8'h00;
            mem_d[k] = 8'h00;
        end
        run_sweep("all_bad");
        check("all_bad.count512", 32'(mismatch_count), 32'd512);

        // Random operands with a handful of random corruptions.
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_a[k] = 8'($urandom_range(0, 255));
                mem_b[k] = 8'($urandom_range(0, 255));
            end
            fill_results();
            for (int j = 0; j < int'($urandom_range(0, 6)); j++) begin
                int idx;
                idx = int'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 1) == 0) mem_s[idx] = mem_s[idx] ^ 8'(1 << $urandom_range(0, 7));
                else                           mem_d[idx] = mem_d[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            run_sweep($sformatf("rand%0d", t));
        end

        // Reset in the middle of a sweep with stale errors present.
        fill_consistent();
        mem_s[5] = mem_s[5] + 8'd1;
        @(negedge clk);
        start = 1'b1;
        repeat (200) @(posedge clk);
        #3;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("midreset.stay_idle", 32'(dut.r_state), 32'(S_IDLE));

        // Clean rerun shows no stale errors.
        fill_consistent();
        run_sweep("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sum_diff_checker.md
# sum_diff_checker

Read-back verifier for the sum/difference RAM pass. It sweeps all addresses of the two operand RAMs (A, B) and the two result RAMs (SUM, DIFF) through their read ports in lock-step. It recomputes `A+B` and `A-B` mod 2^DATA_W and counts mismatches. It reports the first failing address and its kind, so that a board-level top can show pass/fail on the LEDs after the writer FSM completes.

## Interface
Parameters:
- `DATA_W`, default 8: RAM word width.
- `ADDR_W`, default 9: address width. Depth is 2^ADDR_W (512).

Ports:
- `CLOCK_50_I` in, 1: the single clock. Everything is on the rising edge.
- `resetn` in, 1: asynchronous, active-low reset.
- `start` in, 1: level request. Sampled only in S_IDLE.
- `rd_addr` out, ADDR_W: shared read address for all four RAM read ports.
- `op_a_q` in, DATA_W: operand RAM A read data.
- `op_b_q` in, DATA_W: operand RAM B read data.
- `sum_q` in, DATA_W: SUM RAM read data.
- `diff_q` in, DATA_W: DIFF RAM read data.
- `busy` out, 1: high in S_READ and S_DRAIN.
- `done` out, 1: high in S_DONE.
- `pass` out, 1: `done && mismatch_count==0`.
- `mismatch_count` out, ADDR_W+1: number of failing addresses.
- `first_err_addr` out, ADDR_W: lowest failing address.
- `first_err_kind` out, 2: bit0 = SUM wrong, bit1 = DIFF wrong, at `first_err_addr`.
- `first_err_valid` out, 1: at least one mismatch was recorded.

## Operation
- FSM states and transitions:
  - S_IDLE: go to S_READ when `start`=1.
  - S_READ: `rd_addr` increments every cycle. After the cycle with `rd_addr`=2^ADDR_W-1, go to S_DRAIN.
  - S_DRAIN: one cycle, then go to S_DONE.
  - S_DONE: hold all results while `start`=1. Return to S_IDLE when `start`=0.
- Entering S_READ clears the counter, `first_err_*`, and `rd_addr` (0).
- RAM read latency is 1: data for the address registered at edge N is valid in the cycle after N. A registered `cmp_valid`/`cmp_addr` pair tracks this.
- Compare rule, for each valid compare:
  - `sum_err = sum_q != (op_a_q+op_b_q)[DATA_W-1:0]`.
  - `diff_err = diff_q != (op_a_q-op_b_q)[DATA_W-1:0]`.
  - Carry and borrow are discarded (modular arithmetic).
- If `sum_err|diff_err`:
  - `mismatch_count` increments by 1 per address, not per field. Maximum value is 512, which fits, so no saturation is needed.
  - If `first_err_valid`=0, capture `cmp_addr` and `{diff_err,sum_err}`, and set `first_err_valid`.
- `start` going low during S_READ or S_DRAIN is ignored; the sweep always completes.
- Read-only block: it drives no write enables and no write data.

## Timing
- Reset values: state S_IDLE; every output 0, including `rd_addr`, `busy`, `done`, `pass`, `mismatch_count`, and all `first_err_*`.
- Cycle-level sweep:
  - Edge E0 samples `start`=1 in S_IDLE.
  - Cycles 1..512 are S_READ, with `rd_addr`=0..511.
  - Cycle 513 is S_DRAIN; compare of address 511 happens at its closing edge.
  - `done`=1 from cycle 514 onward.
- `rd_addr` wraps 511→0 at the S_READ→S_DRAIN edge.
  - The S_DRAIN address is never compared.
  - `rd_addr` holds 0 in S_DONE and S_IDLE.
- Reset asserted at any point: every register returns to its reset value immediately. A later `start` begins a fresh sweep.
- `start` high at reset release: the sweep begins at the first clock edge.

## Structure
- Shared package `sum_diff_pkg`:
  - State enum type `sum_diff_state_t` {S_IDLE, S_READ, S_DRAIN, S_DONE}.
  - Constants `SD_DATA_W=8`, `SD_ADDR_W=9`, `SD_DEPTH=512`.
  - Error-kind constants `ERR_SUM=2'b01`, `ERR_DIFF=2'b10`.
- One natural sub-module: `sum_diff_compare`. It is purely combinational; it takes A, B, SUM, DIFF and produces `{diff_err,sum_err}`, and can be reused by the writer's self-test. The FSM, pipeline registers and counters stay in the top.

## Test plan
- Consistent RAMs (A[k]=k[7:0], B[k]=(3k)[7:0], SUM/DIFF correct), `start`=1 -> `done` rises on cycle 514; `mismatch_count`=0; `pass`=1; `first_err_valid`=0.
- SUM[37] corrupted (+1) -> `mismatch_count`=1, `first_err_addr`=37, `first_err_kind`=2'b01, `pass`=0.
- DIFF[0] and DIFF[511] corrupted -> count=2, `first_err_addr`=0, kind=2'b10. This proves address 511 is compared in S_DRAIN.
- A=0xFF, B=0x01 everywhere, SUM=0x00, DIFF=0xFE -> count=0. Overflow and borrow wrap correctly.
- All SUM and DIFF entries zeroed against nonzero operands -> count=512, `first_err_addr`=0, kind=2'b11.
- `resetn` low during cycle 200 -> all outputs 0 and state S_IDLE. A clean rerun then yields count=0 with no stale errors. `start` held through `done` keeps results; dropping `start` returns to S_IDLE.
